// File: rtl/heat_column_param.sv
//==============================================================================
// Module   : heat_column_param
// Brief    : One column of a 2-D explicit heat-diffusion grid. Holds the column
//            in a private RAM and sweeps it one row at a time with a Jacobi
//            update, exchanging old values with lockstep neighbour columns.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module heat_column_param #(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 27,
  parameter int ROW_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ROW_BITS-1:0] height,
  input  logic [DATA_W-1:0]   alpha,
  input  logic [1:0]          bc_mode,
  input  logic [DATA_W-1:0]   bc_value,
  input  logic                src_en,
  input  logic [ROW_BITS-1:0] src_row,
  input  logic [DATA_W-1:0]   src_value,
  input  logic [DATA_W-1:0]   node_left,
  input  logic [DATA_W-1:0]   node_right,
  input  logic                start,
  output logic [DATA_W-1:0]   node_center,
  output logic                init_done,
  output logic                busy,
  output logic                done,
  output logic [15:0]         sweep_count,
  input  logic                rd_en,
  input  logic [ROW_BITS-1:0] rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int LAP_W  = DATA_W + 3;
  localparam int PROD_W = DATA_W + LAP_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int DEPTH  = 1 << ROW_BITS;
  localparam logic [DATA_W-1:0] C_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] C_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_CALC  = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
  logic [DATA_W-1:0]   r_ram_q;
  logic [ROW_BITS-1:0] r_row;
  logic [ROW_BITS-1:0] r_height;
  logic [ROW_BITS-1:0] r_src_row;
  logic [DATA_W-1:0]   r_src_value;
  logic                r_src_en;
  logic [DATA_W-1:0]   r_alpha;
  logic [1:0]          r_bc_mode;
  logic [DATA_W-1:0]   r_bc_value;
  logic [DATA_W-1:0]   r_center;
  logic [DATA_W-1:0]   r_down;
  logic [DATA_W-1:0]   r_new;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_done;
  logic                r_init_done;
  logic [15:0]         r_count;

  // During INIT the height/source inputs are used live; they are captured
  // every INIT cycle so the registered copies are valid on leaving INIT.
  logic                w_in_init;
  logic [ROW_BITS-1:0] w_height;
  logic                w_src_en;
  logic [ROW_BITS-1:0] w_src_row;
  logic [DATA_W-1:0]   w_src_value;
  logic                w_last;
  logic                w_src_hit;

  assign w_in_init   = (r_state == S_INIT);
  assign w_height    = w_in_init ? height    : r_height;
  assign w_src_en    = w_in_init ? src_en    : r_src_en;
  assign w_src_row   = w_in_init ? src_row   : r_src_row;
  assign w_src_value = w_in_init ? src_value : r_src_value;
  assign w_last      = (r_row == w_height);
  assign w_src_hit   = w_src_en && (r_row == w_src_row);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (w_last) w_next = S_IDLE;
      S_IDLE:  if (start)  w_next = S_FETCH;
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_CALC;
      S_CALC:  w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_IDLE : S_FETCH;
      default: w_next = S_INIT;
    endcase
  end

  // Read port: in a sweep it always points one row ahead, giving "up" in CALC
  // and the next row's centre at the WRITE edge (that row is not yet written).
  logic [ROW_BITS-1:0] w_rd_addr;
  logic [DATA_W-1:0]   w_mem_rd;
  logic                w_we;
  logic [DATA_W-1:0]   w_wr_data;

  always_comb begin
    w_rd_addr = r_row + ROW_BITS'(1);
    if (r_state == S_IDLE) w_rd_addr = start ? '0 : rd_addr;
  end

  assign w_mem_rd  = r_mem[w_rd_addr];
  assign w_we      = (r_state == S_INIT) || (r_state == S_WRITE);
  assign w_wr_data = w_src_hit ? w_src_value :
                     (r_state == S_WRITE) ? r_new : '0;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_row] <= w_wr_data;
    r_ram_q <= w_mem_rd;
  end

  // Update datapath: new = center + (alpha * laplacian) >>> FRAC_W, saturated.
  logic [DATA_W-1:0]        w_bc_val;
  logic [DATA_W-1:0]        w_up;
  logic [DATA_W-1:0]        w_dn;
  logic signed [LAP_W-1:0]  w_lap;
  logic signed [PROD_W-1:0] w_alpha_x;
  logic signed [PROD_W-1:0] w_lap_x;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_delta;
  logic signed [SUM_W-1:0]  w_sum;
  logic [SUM_W-DATA_W:0]    w_top;
  logic                     w_ovf;
  logic [DATA_W-1:0]        w_new;

  always_comb begin
    case (r_bc_mode)
      2'b01:   w_bc_val = r_bc_value;
      2'b10:   w_bc_val = r_center;
      default: w_bc_val = '0;
    endcase
  end

  assign w_dn = (r_row == '0) ? w_bc_val : r_down;
  assign w_up = w_last ? w_bc_val : r_ram_q;

  assign w_lap = {{3{w_up[DATA_W-1]}},         w_up}
               + {{3{w_dn[DATA_W-1]}},         w_dn}
               + {{3{node_left[DATA_W-1]}},    node_left}
               + {{3{node_right[DATA_W-1]}},   node_right}
               - {r_center[DATA_W-1], r_center, 2'b00};

  assign w_alpha_x = {{(PROD_W-DATA_W){r_alpha[DATA_W-1]}}, r_alpha};
  assign w_lap_x   = {{(PROD_W-LAP_W){w_lap[LAP_W-1]}}, w_lap};
  assign w_prod    = w_alpha_x * w_lap_x;
  assign w_delta   = w_prod >>> FRAC_W;
  assign w_sum     = {w_delta[PROD_W-1], w_delta}
                   + {{(SUM_W-DATA_W){r_center[DATA_W-1]}}, r_center};
  assign w_top     = w_sum[SUM_W-1:DATA_W-1];
  assign w_ovf     = !((&w_top) || !(|w_top));
  assign w_new     = w_ovf ? (w_sum[SUM_W-1] ? C_MIN : C_MAX) : w_sum[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row       <= '0;
      r_height    <= '0;
      r_src_row   <= '0;
      r_src_value <= '0;
      r_src_en    <= 1'b0;
      r_alpha     <= '0;
      r_bc_mode   <= 2'b00;
      r_bc_value  <= '0;
      r_center    <= '0;
      r_down      <= '0;
      r_new       <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_init_done <= 1'b0;
      r_count     <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_height    <= height;
          r_src_en    <= src_en;
          r_src_row   <= src_row;
          r_src_value <= src_value;
          if (w_last) begin
            r_row       <= '0;
            r_init_done <= 1'b1;
          end else begin
            r_row <= r_row + ROW_BITS'(1);
          end
        end
        S_IDLE: begin
          if (start) begin
            r_height    <= height;
            r_src_en    <= src_en;
            r_src_row   <= src_row;
            r_src_value <= src_value;
            r_alpha     <= alpha;
            r_bc_mode   <= bc_mode;
            r_bc_value  <= bc_value;
            r_row       <= '0;
            r_center    <= w_mem_rd;
          end else if (rd_en) begin
            r_rd_data  <= w_mem_rd;
            r_rd_valid <= 1'b1;
          end
        end
        S_CALC: r_new <= w_new;
        S_WRITE: begin
          r_down <= r_center;
          if (w_last) begin
            r_done  <= 1'b1;
            r_count <= r_count + 16'd1;
            r_row   <= '0;
          end else begin
            r_row    <= r_row + ROW_BITS'(1);
            r_center <= w_mem_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign node_center = r_center;
  assign init_done   = r_init_done;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign sweep_count = r_count;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_heat_column_param.sv
//==============================================================================
// Module   : tb_heat_column_param
// Brief    : Directed bench for heat_column_param with a reference column model
//            and a readout scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_heat_column_param;

  localparam logic [31:0] ONE     = 32'h0800_0000;
  localparam logic [31:0] HALF    = 32'h0400_0000;
  localparam logic [31:0] QUARTER = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  height;
  logic [31:0] alpha;
  logic [1:0]  bc_mode;
  logic [31:0] bc_value;
  logic        src_en;
  logic [7:0]  src_row;
  logic [31:0] src_value;
  logic [31:0] node_left;
  logic [31:0] node_right;
  logic        start;
  logic [31:0] node_center;
  logic        init_done;
  logic        busy;
  logic        done;
  logic [15:0] sweep_count;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  heat_column_param #(.DATA_W(32), .FRAC_W(27), .ROW_BITS(8)) dut (
    .clk(clk), .reset(reset), .height(height), .alpha(alpha),
    .bc_mode(bc_mode), .bc_value(bc_value), .src_en(src_en),
    .src_row(src_row), .src_value(src_value), .node_left(node_left),
    .node_right(node_right), .start(start), .node_center(node_center),
    .init_done(init_done), .busy(busy), .done(done),
    .sweep_count(sweep_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [31:0]        sb[$];
  logic signed [31:0] model_mem [256];
  logic signed [31:0] model_old [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_cell(input logic signed [31:0] c, u, d, l, r, a);
    logic signed [127:0] xc, xu, xd, xl, xr, xa, lap, nv;
    logic signed [127:0] mx, mn;
    xc = c; xu = u; xd = d; xl = l; xr = r; xa = a;
    mx  = 128'sh7FFF_FFFF;
    mn  = -128'sh8000_0000;
    lap = xu + xd + xl + xr - 4 * xc;
    nv  = xc + ((lap * xa) >>> 27);
    if (nv > mx) return 32'h7FFF_FFFF;
    if (nv < mn) return 32'h8000_0000;
    return nv[31:0];
  endfunction

  task automatic model_init(input int h, input logic se, input int sr, input logic [31:0] sv);
    for (int i = 0; i <= h; i++) model_mem[i] = (se && i == sr) ? sv : 32'h0;
  endtask

  task automatic model_sweep(input int h, input logic [31:0] a, input logic [1:0] bcm,
                             input logic [31:0] bcv, input logic se, input int sr,
                             input logic [31:0] sv, input logic [31:0] l, input logic [31:0] r);
    logic signed [31:0] c, u, d, bc;
    for (int i = 0; i < 256; i++) model_old[i] = model_mem[i];
    for (int i = 0; i <= h; i++) begin
      c  = model_old[i];
      bc = (bcm == 2'b01) ? bcv : (bcm == 2'b10) ? c : 32'sh0;
      if (i == 0) d = bc; else d = model_old[i-1];
      if (i == h) u = bc; else u = model_old[i+1];
      model_mem[i] = (se && i == sr) ? sv : ref_cell(c, u, d, l, r, a);
    end
  endtask

  task automatic do_reset(input int h, input logic se, input int sr, input logic [31:0] sv);
    int n;
    logic saw_done;
    @(negedge clk);
    reset = 1'b0; height = 8'(h); src_en = se; src_row = 8'(sr); src_value = sv;
    start = 1'b0; rd_en = 1'b0;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_done", done, 0);
    chk("rst_sweep_count", sweep_count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_node_center", node_center, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;
    model_init(h, se, sr, sv);
    n = 0; saw_done = 1'b0;
    while (init_done !== 1'b1 && n < 600) begin
      @(posedge clk); #1; n++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("init_len", n, h + 1);
    chk("init_no_done", saw_done, 0);
  endtask

  task automatic rd_row(input int a, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 8'(a);
    sb.push_back(exp);
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_valid", rd_valid, 1);
    e = sb.pop_front();
    if (rd_valid === 1'b1) chk("rd_data", rd_data, e);
  endtask

  task automatic read_all(input int h);
    for (int i = 0; i <= h; i++) rd_row(i, model_mem[i]);
  endtask

  task automatic sweep(input int h, input logic [31:0] a, input logic [1:0] bcm,
                       input logic [31:0] bcv, input logic se, input int sr,
                       input logic [31:0] sv, input logic [31:0] l, input logic [31:0] r);
    int n;
    @(negedge clk);
    height = 8'(h); alpha = a; bc_mode = bcm; bc_value = bcv;
    src_en = se; src_row = 8'(sr); src_value = sv;
    node_left = l; node_right = r;
    start = 1'b1; rd_en = 1'b1; rd_addr = 8'd0;
    model_sweep(h, a, bcm, bcv, se, sr, sv, l, r);
    exp_cnt++;
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1; n++;
      start = (n == 5 && h > 0);
      rd_en = start;
      if (n == 1) begin
        chk("rd_with_start", rd_valid, 0);
        chk("busy_in_sweep", busy, 1);
      end
      if (n == 6 && h > 0) chk("rd_while_busy", rd_valid, 0);
      if (n <= 4 * (h + 1) && (n - 1) % 4 == 0)
        chk("node_center", node_center, model_old[(n - 1) / 4]);
      if (done === 1'b1) break;
    end
    start = 1'b0; rd_en = 1'b0;
    chk("sweep_len", n, 4 * (h + 1) + 1);
    chk("sweep_count", sweep_count, exp_cnt[15:0]);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    reset = 1'b0; height = 8'd7; alpha = 32'h0; bc_mode = 2'b00; bc_value = 32'h0;
    src_en = 1'b0; src_row = 8'd0; src_value = 32'h0; node_left = 32'h0;
    node_right = 32'h0; start = 1'b0; rd_en = 1'b0; rd_addr = 8'd0;

    // Plain initialisation: all rows zero.
    do_reset(7, 1'b0, 0, 32'h0);
    read_all(7);

    // Single hot row diffusing into its neighbours.
    do_reset(7, 1'b1, 3, ONE);
    read_all(7);
    sweep(7, QUARTER, 2'b00, 32'h0, 1'b1, 3, ONE, 32'h0, 32'h0);
    rd_row(2, QUARTER);
    rd_row(3, ONE);
    rd_row(4, QUARTER);
    rd_row(0, 32'h0);
    rd_row(7, 32'h0);
    read_all(7);

    // Fill every row with 0.5 using alpha=0 sweeps, then insulated sweeps.
    for (int k = 0; k < 8; k++) sweep(7, 32'h0, 2'b00, 32'h0, 1'b1, k, HALF, 32'h0, 32'h0);
    for (int k = 0; k < 10; k++) sweep(7, QUARTER, 2'b10, 32'h0, 1'b0, 0, 32'h0, HALF, HALF);
    for (int i = 0; i < 8; i++) rd_row(i, HALF);

    // Saturation at both rails with a single-row column.
    do_reset(0, 1'b1, 0, 32'h7FFF_0000);
    sweep(0, 32'h7FFF_FFFF, 2'b01, 32'h7FFF_FFFF, 1'b0, 0, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    rd_row(0, 32'h7FFF_FFFF);
    do_reset(0, 1'b1, 0, 32'h8001_0000);
    sweep(0, 32'h7FFF_FFFF, 2'b01, 32'h8000_0000, 1'b0, 0, 32'h0, 32'h8000_0000, 32'h8000_0000);
    rd_row(0, 32'h8000_0000);

    // Mixed boundary modes and random data against the model.
    do_reset(15, 1'b1, 5, $urandom);
    for (int i = 0; i < 6; i++) begin
      sweep(15, (i == 3) ? 32'hF800_0000 : $urandom_range(0, 32'h0800_0000), 2'(i % 4),
            $urandom, 1'(i % 2), $urandom_range(0, 15), $urandom, $urandom, $urandom);
    end
    read_all(15);

    // Reset during row 4 of a sweep: aborted, no done, INIT replays.
    @(negedge clk);
    height = 8'd7; alpha = QUARTER; bc_mode = 2'b00; src_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("abort_center_row4", node_center, model_mem[4]);
    chk("abort_no_done", done, 0);
    chk("abort_count_before", sweep_count, exp_cnt[15:0]);
    do_reset(7, 1'b0, 0, 32'h0);
    read_all(7);
    sweep(7, QUARTER, 2'b01, HALF, 1'b0, 0, 32'h0, 32'h0, 32'h0);
    read_all(7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
